// File: rtl/hilo_div_unit_pkg.sv
// Shared definitions for the HI/LO divider: FSM state encodings.
package hilo_div_unit_pkg;

  typedef logic [1:0] div_state_t;

  localparam div_state_t DIV_IDLE = 2'd0;
  localparam div_state_t DIV_BUSY = 2'd1;
  localparam div_state_t DIV_DONE = 2'd2;

endpackage

// File: rtl/hilo_div_unit_if.sv
// EXE-stage request/response bundle for the divider; master = pipeline, slave = divider.
interface hilo_div_unit_if #(
  parameter int DATA_W = 32
);

  logic                  start_i;
  logic                  signed_i;
  logic [DATA_W-1:0]     dividend_i;
  logic [DATA_W-1:0]     divisor_i;
  logic                  cancel_i;
  logic                  stall_o;
  logic                  busy_o;
  logic                  done_o;
  logic [2*DATA_W-1:0]   hilo_o;

  modport master (
    output start_i, signed_i, dividend_i, divisor_i, cancel_i,
    input  stall_o, busy_o, done_o, hilo_o
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i, cancel_i,
    output stall_o, busy_o, done_o, hilo_o
  );

endinterface

// File: rtl/hilo_div_unit_div_step.sv
// One restoring-division step: shifts the next dividend bit into the partial
// remainder and records one quotient bit, MSB first.
module hilo_div_unit_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quot_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quot_o
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // rem_i < divisor_i always holds, so diff's top bit is a clean borrow flag
  always_comb begin
    shifted = {rem_i, quot_i[DATA_W-1]};
    diff    = shifted - {1'b0, divisor_i};
    if (!diff[DATA_W]) begin
      rem_o  = diff[DATA_W-1:0];
      quot_o = {quot_i[DATA_W-2:0], 1'b1};
    end else begin
      rem_o  = shifted[DATA_W-1:0];
      quot_o = {quot_i[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_div_unit.sv
// Multi-cycle DIV/DIVU unit: divides magnitudes one bit per cycle and applies
// sign fix-up on the way into the HI (remainder) / LO (quotient) result register.
module hilo_div_unit
  import hilo_div_unit_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic            clk,
  input  logic            rst,
  hilo_div_unit_if.slave  bus
);

  div_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]    quot_q, quot_d;
  logic [DATA_W-1:0]    dvsr_q, dvsr_d;
  logic                 neg_quot_q, neg_quot_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0]  hilo_q, hilo_d;
  logic [DATA_W-1:0]    step_rem, step_quot;
  logic                 start_ok;
  logic                 dvd_neg, dvs_neg;

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic neg);
    return neg ? -v : v;
  endfunction

  hilo_div_unit_div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quot_o    (step_quot)
  );

  assign start_ok = bus.start_i & ~bus.cancel_i;
  assign dvd_neg  = bus.signed_i & bus.dividend_i[DATA_W-1];
  assign dvs_neg  = bus.signed_i & bus.divisor_i[DATA_W-1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvsr_d     = dvsr_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    hilo_d     = hilo_q;
    case (state_q)
      DIV_IDLE: begin
        if (start_ok) begin
          if (bus.divisor_i == '0) begin
            state_d = DIV_DONE;
            hilo_d  = {bus.dividend_i, {DATA_W{1'b1}}};
          end else begin
            state_d    = DIV_BUSY;
            cnt_d      = '0;
            rem_d      = '0;
            quot_d     = cond_neg(bus.dividend_i, dvd_neg);
            dvsr_d     = cond_neg(bus.divisor_i, dvs_neg);
            neg_quot_d = dvd_neg ^ dvs_neg;
            neg_rem_d  = dvd_neg;
          end
        end
      end
      DIV_BUSY: begin
        if (bus.cancel_i) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d  = step_rem;
          quot_d = step_quot;
          cnt_d  = cnt_q + CNT_W'(1);
          // Last bit: the step outputs are the final magnitudes
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = DIV_DONE;
            hilo_d  = {cond_neg(step_rem, neg_rem_q), cond_neg(step_quot, neg_quot_q)};
          end
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      hilo_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      hilo_q     <= hilo_d;
    end
  end

  // Working registers are always (re)loaded on start, so they need no reset
  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    quot_q <= quot_d;
    dvsr_q <= dvsr_d;
  end

  assign bus.busy_o  = (state_q == DIV_BUSY);
  assign bus.done_o  = (state_q == DIV_DONE);
  assign bus.stall_o = ((state_q == DIV_IDLE) & start_ok) | (state_q == DIV_BUSY);
  assign bus.hilo_o  = hilo_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Bench for hilo_div_unit: 32-bit and 8-bit builds against an arithmetic reference model.
module tb_hilo_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hilo_div_unit_if #(.DATA_W(32)) b32();
  hilo_div_unit_if #(.DATA_W(8))  b8();

  hilo_div_unit #(.DATA_W(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  hilo_div_unit #(.DATA_W(8))  dut8  (.clk(clk), .rst(rst), .bus(b8.slave));

  int checks = 0;
  int errors = 0;
  logic [63:0] last32 = '0;

  // Reference: plain integer division; SV signed / and % truncate toward zero.
  function automatic logic [63:0] model(input int w, input bit s,
                                        input logic [63:0] a_in, input logic [63:0] d_in);
    logic [63:0] mask, a, d, q, r;
    longint sa, sd, sq, sr;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    d = d_in & mask;
    if (d == 64'd0) return (a << w) | mask;
    if (!s) begin
      q = a / d;
      r = a % d;
    end else begin
      sa = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
      sd = d[w-1] ? longint'(d) - longint'(64'd1 << w) : longint'(d);
      sq = sa / sd;
      sr = sa % sd;
      q = 64'(sq);
      r = 64'(sr);
    end
    return ((r & mask) << w) | (q & mask);
  endfunction

  // Returns in the done cycle (or after a 100-cycle bound); lat counts sampled cycles
  // starting with the request cycle, so done after E(W) is lat = W + 2.
  task automatic run32(input bit s, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output int stalls, output int busys,
                       output logic [63:0] res, output bit ok);
    @(negedge clk);
    b32.start_i = 1'b1; b32.signed_i = s; b32.dividend_i = a; b32.divisor_i = d;
    b32.cancel_i = 1'b0;
    lat = 0; stalls = 0; busys = 0; res = '0; ok = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      #1;
      if (b32.stall_o) stalls++;
      if (b32.busy_o) busys++;
      if (b32.done_o) begin
        lat = c; res = b32.hilo_o; ok = 1'b1;
        break;
      end
      @(negedge clk);
      b32.dividend_i = $urandom; b32.divisor_i = $urandom; b32.signed_i = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run8(input bit s, input logic [7:0] a, input logic [7:0] d,
                      output int lat, output int busys, output logic [15:0] res, output bit ok);
    @(negedge clk);
    b8.start_i = 1'b1; b8.signed_i = s; b8.dividend_i = a; b8.divisor_i = d; b8.cancel_i = 1'b0;
    lat = 0; busys = 0; res = '0; ok = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      #1;
      if (b8.busy_o) busys++;
      if (b8.done_o) begin
        lat = c; res = b8.hilo_o; ok = 1'b1;
        break;
      end
      @(negedge clk);
      b8.dividend_i = 8'($urandom); b8.divisor_i = 8'($urandom);
    end
    @(negedge clk);
    b8.start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({b32.stall_o, b32.busy_o, b32.done_o, b32.hilo_o} !== 67'd0) begin
      errors++;
      $display("FAIL reset32 got stall=%b busy=%b done=%b hilo=%h want all 0",
               b32.stall_o, b32.busy_o, b32.done_o, b32.hilo_o);
    end
    checks++;
    if ({b8.stall_o, b8.busy_o, b8.done_o, b8.hilo_o} !== 19'd0) begin
      errors++;
      $display("FAIL reset8 got stall=%b busy=%b done=%b hilo=%h want all 0",
               b8.stall_o, b8.busy_o, b8.done_o, b8.hilo_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    bit          ts [7] = '{0, 1, 1, 1, 0, 0, 1};
    logic [31:0] ta [7] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'h80000000, 32'd5, 32'd5};
    logic [31:0] td [7] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [63:0] te [7] = '{{32'd2, 32'd14}, {32'hFFFFFFFF, 32'hFFFFFFFD}, {32'd1, 32'hFFFFFFFD},
                            {32'd0, 32'h80000000}, {32'h80000000, 32'd0},
                            {32'd5, 32'hFFFFFFFF}, {32'd5, 32'hFFFFFFFF}};
    int lat, stalls, busys;
    logic [63:0] res;
    bit ok;
    for (int i = 0; i < 7; i++) begin
      run32(ts[i], ta[i], td[i], lat, stalls, busys, res, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL dir%0d_timeout no done_o within 100 cycles", i);
      end
      checks++;
      if (res !== te[i] || res !== model(32, ts[i], ta[i], td[i])) begin
        errors++;
        $display("FAIL dir%0d_hilo got %h want %h", i, res, te[i]);
      end
      checks++;
      if (td[i] == 32'd0 ? (lat !== 2 || stalls !== 1 || busys !== 0)
                         : (lat !== 34 || stalls !== 33 || busys !== 32)) begin
        errors++;
        $display("FAIL dir%0d_timing got lat=%0d stall=%0d busy=%0d want %s", i, lat, stalls, busys,
                 td[i] == 32'd0 ? "2/1/0" : "34/33/32");
      end
      last32 = te[i];
      // start still high through DONE: must not re-trigger
      @(negedge clk);
      b32.start_i = 1'b0;
      #1;
      checks++;
      if (b32.done_o !== 1'b0 || b32.busy_o !== 1'b0 || b32.hilo_o !== last32) begin
        errors++;
        $display("FAIL dir%0d_after got done=%b busy=%b hilo=%h want 0 0 %h",
                 i, b32.done_o, b32.busy_o, b32.hilo_o, last32);
      end
    end
  endtask

  task automatic test_random();
    int lat, stalls, busys;
    logic [63:0] res, exp;
    logic [31:0] a, d;
    bit s, ok;
    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: d = 32'd0;
        1: d = 32'd1;
        2: d = 32'hFFFFFFFF;
        3: d = 32'($urandom_range(2, 300));
        default: d = $urandom >> $urandom_range(0, 31);
      endcase
      if (i % 7 == 3) a = 32'h80000000;
      exp = model(32, s, a, d);
      run32(s, a, d, lat, stalls, busys, res, ok);
      checks++;
      if (!ok || res !== exp || lat !== (d == 0 ? 2 : 34)) begin
        errors++;
        $display("FAIL rand%0d s=%0d %h/%h got hilo=%h lat=%0d want %h lat=%0d",
                 i, s, a, d, res, lat, exp, d == 0 ? 2 : 34);
      end
      last32 = exp;
      @(negedge clk);
      b32.start_i = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int lat, stalls, busys;
    logic [63:0] res, exp;
    logic [31:0] a, d;
    bit s, ok;
    for (int i = 0; i < 4; i++) begin
      s = 1'(i);
      a = $urandom;
      d = (i == 2) ? 32'd0 : ($urandom >> 8) | 32'd1;
      exp = model(32, s, a, d);
      run32(s, a, d, lat, stalls, busys, res, ok);
      checks++;
      if (!ok || res !== exp || lat !== (d == 0 ? 2 : 34)) begin
        errors++;
        $display("FAIL b2b%0d got hilo=%h lat=%0d want %h lat=%0d", i, res, lat, exp, d == 0 ? 2 : 34);
      end
      last32 = exp;
    end
    @(negedge clk);
    b32.start_i = 1'b0;
  endtask

  task automatic test_cancel();
    int lat, stalls, busys, dones;
    logic [63:0] res;
    bit ok;
    @(negedge clk);
    b32.start_i = 1'b1; b32.signed_i = 1'b0; b32.dividend_i = 32'd100; b32.divisor_i = 32'd7;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (b32.busy_o !== 1'b1) begin
      errors++;
      $display("FAIL cancel_busy got busy=%b want 1", b32.busy_o);
    end
    b32.cancel_i = 1'b1; b32.start_i = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (b32.busy_o !== 1'b0 || b32.done_o !== 1'b0 || b32.stall_o !== 1'b0 || b32.hilo_o !== last32) begin
      errors++;
      $display("FAIL cancel_idle got busy=%b done=%b stall=%b hilo=%h want 0 0 0 %h",
               b32.busy_o, b32.done_o, b32.stall_o, b32.hilo_o, last32);
    end
    b32.cancel_i = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (b32.done_o) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL cancel_nodone got %0d done pulses want 0", dones);
    end
    // cancel in IDLE suppresses the request
    @(negedge clk);
    b32.start_i = 1'b1; b32.cancel_i = 1'b1; b32.dividend_i = 32'd50; b32.divisor_i = 32'd5;
    #1;
    checks++;
    if (b32.stall_o !== 1'b0) begin
      errors++;
      $display("FAIL cancel_idle_stall got %b want 0", b32.stall_o);
    end
    @(negedge clk);
    b32.start_i = 1'b0; b32.cancel_i = 1'b0;
    #1;
    checks++;
    if (b32.busy_o !== 1'b0 || b32.done_o !== 1'b0) begin
      errors++;
      $display("FAIL cancel_idle_start got busy=%b done=%b want 0 0", b32.busy_o, b32.done_o);
    end
    run32(1'b0, 32'd9, 32'd3, lat, stalls, busys, res, ok);
    checks++;
    if (!ok || res !== {32'd0, 32'd3} || lat !== 34) begin
      errors++;
      $display("FAIL cancel_next got hilo=%h lat=%0d want %h lat=34", res, lat, {32'd0, 32'd3});
    end
    last32 = {32'd0, 32'd3};
    // cancel while in DONE has no effect on the completed result
    b32.cancel_i = 1'b1; b32.start_i = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (b32.hilo_o !== last32 || b32.done_o !== 1'b0 || b32.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL cancel_done got hilo=%h done=%b busy=%b want %h 0 0",
               b32.hilo_o, b32.done_o, b32.busy_o, last32);
    end
    b32.cancel_i = 1'b0;
  endtask

  task automatic test_rst_mid();
    int lat, stalls, busys;
    logic [63:0] res;
    bit ok;
    @(negedge clk);
    b32.start_i = 1'b1; b32.signed_i = 1'b1; b32.dividend_i = 32'hFFFFFF00; b32.divisor_i = 32'd3;
    repeat (20) @(negedge clk);
    rst = 1'b1; b32.start_i = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({b32.stall_o, b32.busy_o, b32.done_o, b32.hilo_o} !== 67'd0) begin
      errors++;
      $display("FAIL rst_mid got stall=%b busy=%b done=%b hilo=%h want all 0",
               b32.stall_o, b32.busy_o, b32.done_o, b32.hilo_o);
    end
    rst = 1'b0;
    last32 = '0;
    run32(1'b1, 32'hFFFFFFF9, 32'd2, lat, stalls, busys, res, ok);
    checks++;
    if (!ok || res !== model(32, 1'b1, 32'hFFFFFFF9, 32'd2) || lat !== 34) begin
      errors++;
      $display("FAIL rst_recover got hilo=%h lat=%0d want %h lat=34",
               res, lat, model(32, 1'b1, 32'hFFFFFFF9, 32'd2));
    end
    @(negedge clk);
    b32.start_i = 1'b0;
  endtask

  task automatic test_width8();
    int lat, busys;
    logic [15:0] res, exp;
    logic [63:0] m;
    logic [7:0] a, d;
    bit s, ok;
    run8(1'b0, 8'd200, 8'd13, lat, busys, res, ok);
    checks++;
    if (!ok || res !== {8'd5, 8'd15} || lat !== 10 || busys !== 8) begin
      errors++;
      $display("FAIL w8_200_13 got hilo=%h lat=%0d busy=%0d want %h 10 8", res, lat, busys, {8'd5, 8'd15});
    end
    for (int i = 0; i < 12; i++) begin
      s = 1'(i & 1);
      a = (i == 4 || i == 5) ? 8'h80 : 8'($urandom);
      d = (i == 4 || i == 5) ? 8'hFF : (i == 6 ? 8'd0 : 8'($urandom));
      m = model(8, s, a, d);
      exp = m[15:0];
      run8(s, a, d, lat, busys, res, ok);
      checks++;
      if (!ok || res !== exp || lat !== (d == 0 ? 2 : 10)) begin
        errors++;
        $display("FAIL w8_rand%0d s=%0d %h/%h got hilo=%h lat=%0d want %h lat=%0d",
                 i, s, a, d, res, lat, exp, d == 0 ? 2 : 10);
      end
    end
  endtask

  initial begin
    b32.start_i = 1'b0; b32.signed_i = 1'b0; b32.dividend_i = '0; b32.divisor_i = '0; b32.cancel_i = 1'b0;
    b8.start_i  = 1'b0; b8.signed_i  = 1'b0; b8.dividend_i  = '0; b8.divisor_i  = '0; b8.cancel_i  = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_cancel();
    test_rst_mid();
    test_width8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish within bound");
    $fatal(1, "watchdog");
  end

endmodule
